// File: rtl/bsg_arb_wrr_pick.sv
// Rotating-priority search: first asserted request at or after ptr_i, wrapping.
module bsg_arb_wrr_pick #(
  parameter int els_p     = 4,
  parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic [els_p-1:0]     reqs_i,
  input  logic [lg_els_lp-1:0] ptr_i,
  output logic [els_p-1:0]     grant_o,
  output logic [lg_els_lp-1:0] id_o,
  output logic                 v_o
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam logic [lg_els_lp:0] els_lp = (lg_els_lp+1)'(els_p);

  logic [lg_els_lp:0] sum;

  // Walk the requesters in priority order and keep the first one found.
  always_comb begin
    grant_o = '0;
    id_o    = '0;
    v_o     = 1'b0;
    sum     = '0;
    for (int i = 0; i < els_p; i++) begin
      sum = {1'b0, ptr_i} + (lg_els_lp+1)'(i);
      if (sum >= els_lp) sum = sum - els_lp;
      if (!v_o && reqs_i[sum[lg_els_lp-1:0]]) begin
        v_o                          = 1'b1;
        id_o                         = sum[lg_els_lp-1:0];
        grant_o[sum[lg_els_lp-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_arb_wrr_locked.sv
// Weighted round-robin arbiter that holds its grant for a whole multi-beat packet.
module bsg_arb_wrr_locked #(
  parameter int els_p          = 4,
  parameter int weight_width_p = 2,
  parameter int lg_els_lp      = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [els_p-1:0]                  reqs_i,
  input  logic                              last_i,
  input  logic                              yumi_i,
  input  logic [els_p*weight_width_p-1:0]   weights_i,
  output logic [els_p-1:0]                  grants_o,
  output logic                              v_o,
  output logic [lg_els_lp-1:0]              grant_id_o,
  output logic                              locked_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                    state_q, state_d;
  logic [lg_els_lp-1:0]      ptr_q, ptr_d;
  logic [weight_width_p-1:0] credit_q, credit_d;
  logic [lg_els_lp-1:0]      lock_id_q, lock_id_d;

  logic [els_p-1:0]          pick_grant;
  logic [lg_els_lp-1:0]      pick_id;
  logic                      pick_v;

  logic                      fire;
  logic [weight_width_p-1:0] credit_c;
  logic [lg_els_lp-1:0]      ptr_nxt;

  // A weight of zero still grants one packet, otherwise the requester would starve.
  function automatic logic [weight_width_p-1:0] eff_weight(
    input logic [lg_els_lp-1:0]              idx,
    input logic [els_p*weight_width_p-1:0]   w
  );
    logic [weight_width_p-1:0] v;
    v = w[int'(idx)*weight_width_p +: weight_width_p];
    return (v == '0) ? weight_width_p'(1) : v;
  endfunction

  function automatic logic [lg_els_lp-1:0] next_id(input logic [lg_els_lp-1:0] g);
    return (g == lg_els_lp'(els_p-1)) ? '0 : g + 1'b1;
  endfunction

  bsg_arb_wrr_pick #(
    .els_p     (els_p),
    .lg_els_lp (lg_els_lp)
  ) u_pick (
    .reqs_i  (reqs_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .id_o    (pick_id),
    .v_o     (pick_v)
  );

  // Grant outputs: free search when idle, lock holder only while a packet is open.
  always_comb begin
    grants_o   = '0;
    grant_id_o = '0;
    if (!reset_i) begin
      if (state_q == LOCKED) begin
        grants_o = (els_p'(1) << lock_id_q) & reqs_i;
        if (|grants_o) grant_id_o = lock_id_q;
      end else if (pick_v) begin
        grants_o   = pick_grant;
        grant_id_o = pick_id;
      end
    end
  end

  assign v_o      = |grants_o;
  assign locked_o = (state_q == LOCKED) && !reset_i;
  assign fire     = yumi_i && v_o;

  // Next-state: lock on a non-final beat, rotate priority/credit when a packet ends.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    credit_d  = credit_q;
    lock_id_d = lock_id_q;
    credit_c  = (grant_id_o == ptr_q) ? credit_q : eff_weight(grant_id_o, weights_i);
    ptr_nxt   = next_id(grant_id_o);
    if (fire) begin
      if (!last_i) begin
        state_d   = LOCKED;
        lock_id_d = grant_id_o;
      end else begin
        state_d = IDLE;
        if (credit_c > weight_width_p'(1)) begin
          ptr_d    = grant_id_o;
          credit_d = credit_c - 1'b1;
        end else begin
          ptr_d    = ptr_nxt;
          credit_d = eff_weight(ptr_nxt, weights_i);
        end
      end
    end
  end

  // State registers; reset reloads requester 0's credit from the live weights.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      credit_q  <= eff_weight('0, weights_i);
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      credit_q  <= credit_d;
      lock_id_q <= lock_id_d;
    end
  end

`ifndef SYNTHESIS
  // Protocol checks: consuming with no grant, or the lock holder dropping its request.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o));
      assert (!(state_q == LOCKED && !reqs_i[lock_id_q]));
    end
  end
`endif

endmodule

// File: tb/tb_bsg_arb_wrr_locked.sv
// Directed bench for bsg_arb_wrr_locked with a queue of expected grant states.
module tb_bsg_arb_wrr_locked;

  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   reqs;
  logic           last;
  logic           yumi;
  logic [2*N-1:0] weights;
  logic [N-1:0]   grants;
  logic           v;
  logic [1:0]     grant_id;
  logic           locked;

  typedef struct {
    logic [N-1:0] grants;
    logic         locked;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  bsg_arb_wrr_locked #(.els_p(N), .weight_width_p(2)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .reqs_i     (reqs),
    .last_i     (last),
    .yumi_i     (yumi),
    .weights_i  (weights),
    .grants_o   (grants),
    .v_o        (v),
    .grant_id_o (grant_id),
    .locked_o   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] onehot_idx(input logic [N-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, queue the expectation, compare on the falling edge.
  task automatic step(input logic rst, input logic [N-1:0] r, input logic y, input logic l,
                      input logic [N-1:0] eg, input logic el, input string tag);
    exp_t e;
    reset = rst;
    reqs  = r;
    yumi  = y;
    last  = l;
    e.grants = eg;
    e.locked = el;
    e.tag    = tag;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.tag, ".grants"}, 32'(grants), 32'(e.grants));
    chk({e.tag, ".v"},      32'(v),      32'(|e.grants));
    chk({e.tag, ".id"},     32'(grant_id), 32'(onehot_idx(e.grants)));
    chk({e.tag, ".locked"}, 32'(locked), 32'(e.locked));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    reqs    = '0;
    yumi    = 1'b0;
    last    = 1'b0;
    weights = 8'b01_01_01_01;
    @(posedge clk);
    #1;

    // 1: reset state, then plain round robin with unit weights
    step(1, 4'b0000, 0, 0, 4'b0000, 0, "t1_in_reset");
    step(0, 4'b0000, 0, 0, 4'b0000, 0, "t1_idle");
    step(0, 4'b1111, 1, 1, 4'b0001, 0, "t1_g0");
    step(0, 4'b1111, 1, 1, 4'b0010, 0, "t1_g1");
    step(0, 4'b1111, 1, 1, 4'b0100, 0, "t1_g2");
    step(0, 4'b1111, 1, 1, 4'b1000, 0, "t1_g3");
    step(0, 4'b1111, 1, 1, 4'b0001, 0, "t1_wrap");

    // 2: requester 0 weighted 3
    weights = 8'b01_01_01_11;
    step(1, 4'b0000, 0, 0, 4'b0000, 0, "t2_reset");
    step(0, 4'b1111, 1, 1, 4'b0001, 0, "t2_a");
    step(0, 4'b1111, 1, 1, 4'b0001, 0, "t2_b");
    step(0, 4'b1111, 1, 1, 4'b0001, 0, "t2_c");
    step(0, 4'b1111, 1, 1, 4'b0010, 0, "t2_d");
    step(0, 4'b1111, 1, 1, 4'b0100, 0, "t2_e");
    step(0, 4'b1111, 1, 1, 4'b1000, 0, "t2_f");
    step(0, 4'b1111, 1, 1, 4'b0001, 0, "t2_g");

    // 3: three-beat packet from requester 0 holds the grant
    weights = 8'b01_01_01_01;
    step(1, 4'b0000, 0, 0, 4'b0000, 0, "t3_reset");
    step(0, 4'b0011, 1, 0, 4'b0001, 0, "t3_beat1");
    step(0, 4'b0011, 1, 0, 4'b0001, 1, "t3_beat2");
    step(0, 4'b0011, 1, 1, 4'b0001, 1, "t3_beat3");
    step(0, 4'b0011, 0, 0, 4'b0010, 0, "t3_next");

    // 4: stall mid-lock, other requests ignored, then complete
    step(1, 4'b0000, 0, 0, 4'b0000, 0, "t4_reset");
    step(0, 4'b0011, 1, 0, 4'b0001, 0, "t4_beat1");
    step(0, 4'b1111, 0, 0, 4'b0001, 1, "t4_stall1");
    step(0, 4'b1111, 0, 0, 4'b0001, 1, "t4_stall2");
    step(0, 4'b1111, 1, 1, 4'b0001, 1, "t4_last");
    step(0, 4'b1111, 0, 0, 4'b0010, 0, "t4_next");

    // 5: pointer at 2, only requester 0 asking -> wraps, then pointer moves to 1
    step(1, 4'b0000, 0, 0, 4'b0000, 0, "t5_reset");
    step(0, 4'b1111, 1, 1, 4'b0001, 0, "t5_p0");
    step(0, 4'b1111, 1, 1, 4'b0010, 0, "t5_p1");
    step(0, 4'b0001, 1, 1, 4'b0001, 0, "t5_wrap");
    step(0, 4'b1111, 0, 0, 4'b0010, 0, "t5_ptr1");

    // 6: reset in the middle of a packet locked on requester 2
    step(1, 4'b0000, 0, 0, 4'b0000, 0, "t6_reset");
    step(0, 4'b1111, 1, 1, 4'b0001, 0, "t6_p0");
    step(0, 4'b1111, 1, 1, 4'b0010, 0, "t6_p1");
    step(0, 4'b1111, 1, 0, 4'b0100, 0, "t6_lock2");
    step(0, 4'b1111, 0, 0, 4'b0100, 1, "t6_locked");
    step(1, 4'b1111, 0, 0, 4'b0000, 0, "t6_midreset");
    step(0, 4'b1111, 0, 0, 4'b0001, 0, "t6_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
